// File: rtl/uart_trace_pkg.sv
// uart_trace_pkg: framer state encoding, header field widths, default sync marker and header builder
package uart_trace_pkg;
  typedef enum logic [2:0] {IDLE, READ, SYNC, HDR, DATA, CSUM} state_t;
  localparam int SEQ_W = 4;
  localparam int CH_W = 4;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  function automatic logic [7:0] header_byte(input logic [SEQ_W-1:0] seq, input logic [CH_W-1:0] ch);
    return {seq, ch};
  endfunction
endpackage

// File: rtl/command_fifo.sv
// command_fifo: power-of-two sync FIFO; in command_in/command_write/command_read, out command_out (head)/full/empty
module command_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] command_in,
  input  logic             command_write,
  input  logic             command_read,
  output logic [WIDTH-1:0] command_out,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign wr = command_write && !full;
  assign rd = command_read && !empty;
  assign command_out = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= command_in;
endmodule

// File: rtl/uart_trace_framer_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; in req/ptr, out gnt_valid/gnt_idx (first request at or after ptr)
module rr_arbiter
  import uart_trace_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic            gnt_valid,
  output logic [CH_W-1:0] gnt_idx
);
  int c;
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    c = 0;
    for (int i = N - 1; i >= 0; i--) begin
      c = (int'(ptr) + i) % N;
      if (req[c]) begin
        gnt_valid = 1'b1;
        gnt_idx = CH_W'(c);
      end
    end
  end
endmodule

// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 transmitter; in trigger/data, out busy (from the cycle after trigger) and txd (idle high)
module uart_transmit #(
  parameter int CLK_FREQ = 240_000_000,
  parameter int BAUD_RATE = 250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  logic [31:0] cnt;
  logic [8:0] sh;
  logic [3:0] bits;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      txd <= 1'b1;
      cnt <= '0;
      sh <= '1;
      bits <= '0;
    end else if (!busy) begin
      if (trigger) begin
        busy <= 1'b1;
        txd <= 1'b0;
        sh <= {1'b1, data};
        cnt <= '0;
        bits <= '0;
      end
    end else if (cnt != 32'(DIV - 1)) begin
      cnt <= cnt + 32'd1;
    end else begin
      cnt <= '0;
      if (bits == 4'd9) busy <= 1'b0;
      else begin
        txd <= sh[0];
        sh <= {1'b1, sh[8:1]};
        bits <= bits + 4'd1;
      end
    end
  end
endmodule

// File: rtl/uart_trace_framer.sv
// uart_trace_framer: per-channel trace FIFOs framed round-robin onto a UART; in trace_data/trace_valid, out ch_full/drop_count/frame_busy/uart_txd
module uart_trace_framer
  import uart_trace_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_WIDTH = 64,
  parameter int IN_DEPTH = 128,
  parameter int TX_DEPTH = 1024,
  parameter int CLK_FREQ = 240_000_000,
  parameter int BAUD_RATE = 250_000,
  parameter int LSB_FIRST = 1,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] trace_data,
  input  logic [NUM_CH-1:0]            trace_valid,
  output logic [NUM_CH-1:0]            ch_full,
  output logic [NUM_CH*16-1:0]         drop_count,
  output logic                         frame_busy,
  output logic                         uart_txd
);
  localparam int NB = DATA_WIDTH / 8;
  state_t state, state_n;
  logic [NUM_CH*DATA_WIDTH-1:0] head;
  logic [NUM_CH-1:0] empty, pop;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CH_W-1:0] rr_ptr, ch_sel, gnt_idx;
  logic [NUM_CH*SEQ_W-1:0] seq;
  logic [SEQ_W-1:0] cur_seq;
  logic [7:0] csum, hdr, cur_byte, tx_byte, tx_out, bcnt;
  logic gnt_valid, tx_wr, tx_full, tx_empty, tx_trigger, tx_trigger_q, uart_busy;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    command_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_fifo (
      .clk, .rst,
      .command_in(trace_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .command_write(trace_valid[c]),
      .command_read(pop[c]),
      .command_out(head[c*DATA_WIDTH +: DATA_WIDTH]),
      .full(ch_full[c]),
      .empty(empty[c])
    );
  end
  rr_arbiter #(.N(NUM_CH)) u_arb (.req(~empty), .ptr(rr_ptr), .gnt_valid, .gnt_idx);
  assign frame_busy = state != IDLE;
  assign pop = state == READ ? NUM_CH'(1) << ch_sel : '0;
  assign cur_seq = seq[ch_sel*SEQ_W +: SEQ_W];
  assign hdr = header_byte(cur_seq, ch_sel);
  assign cur_byte = LSB_FIRST != 0 ? shreg[7:0] : shreg[DATA_WIDTH-1 -: 8];
  assign tx_wr = !tx_full && (state == SYNC || state == HDR || state == DATA || state == CSUM);
  assign tx_byte = state == SYNC ? SYNC_BYTE : state == HDR ? hdr : state == DATA ? cur_byte : csum;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = gnt_valid ? READ : IDLE;
      READ: state_n = SYNC;
      SYNC: state_n = tx_full ? SYNC : HDR;
      HDR: state_n = tx_full ? HDR : DATA;
      DATA: state_n = !tx_full && bcnt == 8'(NB - 1) ? CSUM : DATA;
      CSUM: state_n = tx_full ? CSUM : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      ch_sel <= '0;
      shreg <= '0;
      csum <= '0;
      bcnt <= '0;
      seq <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && gnt_valid) begin
        ch_sel <= gnt_idx;
        rr_ptr <= gnt_idx == CH_W'(NUM_CH - 1) ? '0 : gnt_idx + CH_W'(1);
      end
      if (state == READ) begin
        shreg <= head[ch_sel*DATA_WIDTH +: DATA_WIDTH];
        bcnt <= '0;
      end
      if (tx_wr && state == HDR) csum <= hdr;
      if (tx_wr && state == DATA) begin
        csum <= csum ^ cur_byte;
        bcnt <= bcnt + 8'd1;
        shreg <= LSB_FIRST != 0 ? shreg >> 8 : shreg << 8;
      end
      if (tx_wr && state == CSUM) seq[ch_sel*SEQ_W +: SEQ_W] <= cur_seq + SEQ_W'(1);
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_CH; i++)
      if (rst) drop_count[i*16 +: 16] <= '0;
      else if (trace_valid[i] && ch_full[i] && drop_count[i*16 +: 16] != 16'hFFFF)
        drop_count[i*16 +: 16] <= drop_count[i*16 +: 16] + 16'd1;
  command_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk, .rst,
    .command_in(tx_byte),
    .command_write(tx_wr),
    .command_read(tx_trigger),
    .command_out(tx_out),
    .full(tx_full),
    .empty(tx_empty)
  );
  // busy appears a cycle after the trigger, so the registered guard stops a second pop of the same slot
  assign tx_trigger = !uart_busy && !tx_empty && !tx_trigger_q;
  always_ff @(posedge clk)
    tx_trigger_q <= rst ? 1'b0 : tx_trigger;
  uart_transmit #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart (
    .clk, .rst,
    .trigger(tx_trigger),
    .data(tx_out),
    .busy(uart_busy),
    .txd(uart_txd)
  );
endmodule

// File: tb/tb_uart_trace_framer.sv
// tb_uart_trace_framer: decodes both UART lines and checks every frame against a byte-level reference model
module tb_uart_trace_framer;
  localparam int NC = 2, DW = 64, DIV = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [NC*DW-1:0] td0 = '0, td1 = '0;
  logic [NC-1:0] tv0 = '0, tv1 = '0, full0, full1;
  logic [NC*16-1:0] dc0, dc1;
  logic fb0, fb1;
  logic [1:0] txd;
  logic [7:0] rx0[$], rx1[$];
  logic [3:0] mseq [2][2];
  logic [63:0] acc[$];
  int n_cmp = 0, n_bad = 0;
  int rk [2];
  bit ract [2];
  logic [7:0] rsh [2];
  uart_trace_framer #(.NUM_CH(NC), .DATA_WIDTH(DW), .IN_DEPTH(128), .TX_DEPTH(4),
    .CLK_FREQ(DIV), .BAUD_RATE(1), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .trace_data(td0), .trace_valid(tv0), .ch_full(full0),
    .drop_count(dc0), .frame_busy(fb0), .uart_txd(txd[0]));
  uart_trace_framer #(.NUM_CH(NC), .DATA_WIDTH(DW), .IN_DEPTH(128), .TX_DEPTH(4),
    .CLK_FREQ(DIV), .BAUD_RATE(1), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .trace_data(td1), .trace_valid(tv1), .ch_full(full1),
    .drop_count(dc1), .frame_busy(fb1), .uart_txd(txd[1]));
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
  always @(negedge clk)
    for (int g = 0; g < 2; g++)
      if (rst) ract[g] = 1'b0;
      else if (!ract[g]) begin
        if (!txd[g]) begin
          ract[g] = 1'b1;
          rk[g] = 0;
        end
      end else begin
        rk[g]++;
        if (rk[g] > DIV && rk[g] < 9 * DIV && rk[g] % DIV == DIV / 2) rsh[g] = {txd[g], rsh[g][7:1]};
        if (rk[g] == 9 * DIV + DIV / 2) begin
          ract[g] = 1'b0;
          if (g == 0) rx0.push_back(rsh[g]);
          else rx1.push_back(rsh[g]);
        end
      end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [87:0] frame(input logic [3:0] s, input logic [3:0] ch, input logic [63:0] w, input bit lsb);
    logic [87:0] f;
    logic [7:0] b, x;
    x = {s, ch};
    f = {8'hA5, s, ch, 72'h0};
    for (int i = 0; i < 8; i++) begin
      b = lsb ? w[8*i +: 8] : w[8*(7-i) +: 8];
      x ^= b;
      f[8*(8-i) +: 8] = b;
    end
    f[7:0] = x;
    return f;
  endfunction
  task automatic expect_frame(input int inst, input int ch, input logic [63:0] w, input string tag);
    logic [87:0] got;
    int t, sz;
    t = 0;
    sz = inst == 0 ? rx0.size() : rx1.size();
    while (sz < 11 && t < 3000) begin
      tick();
      t++;
      sz = inst == 0 ? rx0.size() : rx1.size();
    end
    if (sz < 11) begin
      chk({tag, "_timeout"}, 128'(sz), 128'd11);
      return;
    end
    got = '0;
    for (int i = 0; i < 11; i++) got = {got[79:0], inst == 0 ? rx0.pop_front() : rx1.pop_front()};
    chk(tag, got, frame(mseq[inst][ch], 4'(ch), w, inst == 0));
    mseq[inst][ch]++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rx0.delete();
    rx1.delete();
    mseq = '{default: '0};
  endtask
  task automatic push(input int ch, input logic [63:0] w);
    td0[ch*DW +: DW] = w;
    tv0[ch] = 1'b1;
    tick();
    tv0 = '0;
  endtask
  initial begin
    logic [63:0] w, a, b;
    int drops, t;
    do_reset();
    tick();
    chk("rst_txd", txd, 2'b11);
    chk("rst_busy", {fb1, fb0}, 2'b00);
    chk("rst_full", {full1, full0}, 4'h0);
    chk("rst_drop", {dc1, dc0}, '0);
    w = 64'h0807060504030201;
    td0[DW-1:0] = w;
    td1[DW-1:0] = w;
    tv0 = 2'b01;
    tv1 = 2'b01;
    tick();
    tv0 = '0;
    tv1 = '0;
    chk("lat_idle_e0", fb0, 1'b0);
    tick();
    chk("lat_busy_e1", fb0, 1'b1);
    expect_frame(0, 0, w, "lsb_first");
    expect_frame(1, 0, w, "msb_first");
    chk("idle_after", {fb1, fb0}, 2'b00);
    do_reset();
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    td0 = {b, a};
    tv0 = 2'b11;
    tick();
    tv0 = 2'b01;
    tick();
    tv0 = '0;
    expect_frame(0, 0, a, "rr_ch0_s0");
    expect_frame(0, 1, b, "rr_ch1_s0");
    expect_frame(0, 0, a, "rr_ch0_s1");
    w = {$urandom, $urandom};
    push(0, w);
    repeat (40) tick();
    drops = 0;
    acc.delete();
    for (int i = 0; i < 130; i++) begin
      a = {$urandom, $urandom};
      if (full0[1]) drops++;
      else acc.push_back(a);
      td0[DW +: DW] = a;
      tv0[1] = 1'b1;
      tick();
    end
    tv0 = '0;
    chk("ovf_drop1", 128'(dc0[31:16]), 128'(drops));
    chk("ovf_drop_range", 128'(drops == 1 || drops == 2), 128'd1);
    chk("ovf_drop0", 128'(dc0[15:0]), 128'd0);
    expect_frame(0, 0, w, "ovf_ch0");
    foreach (acc[i]) expect_frame(0, 1, acc[i], $sformatf("ovf_ch1_%0d", i));
    acc.delete();
    for (int i = 0; i < 17; i++) begin
      a = {$urandom, $urandom};
      acc.push_back(a);
      td0[DW-1:0] = a;
      tv0[0] = 1'b1;
      tick();
    end
    tv0 = '0;
    foreach (acc[i]) expect_frame(0, 0, acc[i], $sformatf("wrap_%0d", i));
    push(0, {$urandom, $urandom});
    tick();
    t = 0;
    while (fb0 && t < 3000) begin
      tick();
      t++;
    end
    chk("f1_done", fb0, 1'b0);
    push(0, {$urandom, $urandom});
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_txd", txd[0], 1'b1);
    chk("mid_rst_busy", fb0, 1'b0);
    chk("mid_rst_drop", dc0, '0);
    chk("mid_rst_full", full0, 2'b00);
    do_reset();
    w = {$urandom, $urandom};
    push(0, w);
    expect_frame(0, 0, w, "post_rst_seq0");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
